ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction-fetch front end and PC register for the RV32 core.
- Consumes the next-PC value produced by the next-PC logic and issues requests to instruction memory over a request/grant/response handshake.
- Buffers the returned instruction and presents it to decode with a valid/ready handshake.
- Loads the next PC only when decode accepts the current instruction. Detects misaligned targets, bus errors and response timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] must be 0.
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT before a timeout fault; must be ≥1.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- npc_i  in  32  next PC from the next-PC logic (PC+4 or PC+IMMEXT), combinational from pc_o.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address; equals pc_o.
- imem_gnt_i  in  1  memory accepts the request this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  32  instruction word.
- imem_err_i  in  1  response carries a bus error; qualified by imem_rvalid_i.
- inst_valid_o  out  1  inst_o is valid for decode.
- inst_o  out  32  buffered instruction.
- inst_ready_i  in  1  decode accepts the instruction.
- pc_o  out  32  PC of the current or pending instruction.
- fault_o  out  1  sticky fault flag.
- fault_cause_o  out  2  00 none, 01 misaligned npc, 10 bus error, 11 timeout.
- fault_pc_o  out  32  offending address.
- retire_cnt_o  out  32  count of accepted instructions; wraps.

Behaviour:

Reset values (rst high at an edge):
- pc_o=RESET_PC, state=REQ, inst_o=0, inst_valid_o=0.
- fault_o=0, fault_cause_o=00, fault_pc_o=0, retire_cnt_o=0, wait counter=0.
- Reset overrides every other input. Reset in any state, including mid-WAIT and FAULT, abandons the outstanding access.

FSM states REQ, WAIT, HOLD, FAULT:
- REQ:
  - imem_req_o=1, imem_addr_o=pc_o.
  - imem_gnt_i=1 → WAIT, wait counter cleared.
  - imem_rvalid_i in REQ is ignored (stale response after reset).
- WAIT:
  - imem_req_o=0.
  - imem_rvalid_i=1 and imem_err_i=1 → FAULT, cause 10, fault_pc_o=pc_o.
  - imem_rvalid_i=1 and imem_err_i=0 → inst_o<=imem_rdata_i, → HOLD.
  - No rvalid and counter==TIMEOUT_CYCLES-1 → FAULT, cause 11, fault_pc_o=pc_o.
  - Otherwise counter increments.
  - A response in the final allowed cycle is accepted (rvalid beats timeout). Error beats data.
- HOLD:
  - inst_valid_o=1; inst_o and pc_o stable until accepted.
  - inst_valid_o never drops without a handshake.
  - On inst_ready_i=1:
    - npc_i[1:0]==00 → pc_o<=npc_i, retire_cnt_o+=1 (wraps 32'hFFFF_FFFF→0), → REQ.
    - npc_i[1:0]!=00 → FAULT, cause 01, fault_pc_o=npc_i, pc_o unchanged, retire_cnt_o+=1 (the instruction itself retired).
- FAULT:
  - fault_o=1, imem_req_o=0, inst_valid_o=0.
  - Absorbing state; only rst exits. Memory inputs are ignored.

Timing and output rules:
- inst_valid_o and fault_o are registered (decoded from state). The first instruction is presented no earlier than 2 cycles after reset release with a 1-cycle-latency memory.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD), with gnt same cycle, rvalid next cycle, and ready immediate.
- fault_cause_o and fault_pc_o are captured once on FAULT entry and held.
- imem_addr_o is driven with pc_o in all states. It is meaningful only when imem_req_o=1.

Test Plan:
- Reset and first fetch: rst 2 cycles, RESET_PC=0x100, memory gnt immediate, rvalid next cycle with 0x00000013, ready=1, npc_i=0x104 → imem_addr_o=0x100; inst_o=0x00000013 with inst_valid_o; pc_o=0x104 after handshake; retire_cnt_o=1.
- Decode backpressure: ready low for 5 cycles in HOLD → inst_valid_o, inst_o, pc_o stable; no new imem_req_o; pc advances only on the ready cycle.
- Branch target: HOLD at pc 0x200, npc_i=0x1F0, ready=1 → next request address 0x1F0. Repeat with npc_i=0x1F2 → FAULT, cause 01, fault_pc_o=0x1F2, pc_o=0x200.
- Bus error: rvalid=1, err=1 at pc 0x300 → fault_o=1, cause 10, fault_pc_o=0x300; later rvalid pulses ignored; rst returns to REQ at RESET_PC.
- Timeout boundary, TIMEOUT_CYCLES=4:
  - rvalid on the 4th WAIT cycle → accepted, no fault.
  - No rvalid through 4 WAIT cycles → FAULT, cause 11.
  - rvalid and err on the 4th cycle → cause 10.
- Counter wrap and reset mid-WAIT: preload via 2^32-1 handshakes (or force) → next handshake gives retire_cnt_o=0. Assert rst during WAIT and then drive rvalid in REQ → response ignored, a fresh request at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: holds the PC, fetches over a req/gnt/rvalid bus,
// and buffers one instruction for decode. Misaligned targets, bus errors and timeouts park it in FAULT.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    input  logic        inst_ready_i,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic [31:0] fault_pc_o,
    output logic [31:0] retire_cnt_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q;
    logic [31:0]   inst_q;
    logic [1:0]    cause_q;
    logic [31:0]   fault_pc_q;
    logic [31:0]   retire_q;
    logic [CW-1:0] wait_q;

    logic          take_rsp;
    logic          take_npc;
    logic          retire;
    logic          fault_set;
    logic [1:0]    cause_d;
    logic [31:0]   fault_pc_d;
    logic          wait_clr;
    logic          wait_inc;

    // Next-state and datapath enables; an error response wins over data,
    // and any response wins over the timeout in the last allowed cycle.
    always_comb begin
        state_d    = state_q;
        take_rsp   = 1'b0;
        take_npc   = 1'b0;
        retire     = 1'b0;
        fault_set  = 1'b0;
        cause_d    = 2'b00;
        fault_pc_d = 32'h0;
        wait_clr   = 1'b0;
        wait_inc   = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (imem_gnt_i) begin
                    state_d  = ST_WAIT;
                    wait_clr = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i && imem_err_i) begin
                    state_d    = ST_FAULT;
                    fault_set  = 1'b1;
                    cause_d    = 2'b10;
                    fault_pc_d = pc_q;
                end else if (imem_rvalid_i) begin
                    state_d  = ST_HOLD;
                    take_rsp = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d    = ST_FAULT;
                    fault_set  = 1'b1;
                    cause_d    = 2'b11;
                    fault_pc_d = pc_q;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                if (inst_ready_i) begin
                    retire = 1'b1;
                    if (npc_i[1:0] == 2'b00) begin
                        state_d  = ST_REQ;
                        take_npc = 1'b1;
                    end else begin
                        state_d    = ST_FAULT;
                        fault_set  = 1'b1;
                        cause_d    = 2'b01;
                        fault_pc_d = npc_i;
                    end
                end
            end
            default: state_d = ST_FAULT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0;
            cause_q    <= 2'b00;
            fault_pc_q <= 32'h0;
            retire_q   <= 32'h0;
            wait_q     <= '0;
        end else begin
            state_q <= state_d;
            if (take_rsp) inst_q <= imem_rdata_i;
            if (take_npc) pc_q <= npc_i;
            if (retire) retire_q <= retire_q + 32'd1;
            if (fault_set) begin
                cause_q    <= cause_d;
                fault_pc_q <= fault_pc_d;
            end
            if (wait_clr) wait_q <= '0;
            else if (wait_inc) wait_q <= wait_q + 1'b1;
        end
    end

    assign imem_req_o    = (state_q == ST_REQ);
    assign imem_addr_o   = pc_q;
    assign inst_valid_o  = (state_q == ST_HOLD);
    assign inst_o        = inst_q;
    assign pc_o          = pc_q;
    assign fault_o       = (state_q == ST_FAULT);
    assign fault_cause_o = cause_q;
    assign fault_pc_o    = fault_pc_q;
    assign retire_cnt_o  = retire_q;

endmodule
